// File: rtl/spio_hss_multiplexer_frame_rx.sv
// Receive-side frame parser for the spiNNlink HSS link: classifies words, checks CRC-16,
// streams verified payload and decodes control frames into single-cycle notifications.
module spio_hss_multiplexer_frame_rx #(
    parameter int FRM_BITS  = 32,
    parameter int KCH_BITS  = 4,
    parameter int SEQ_BITS  = 7,
    parameter int CLR_BITS  = 1,
    parameter int NUM_CHANS = 8,
    parameter int IDLE_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FRM_BITS-1:0]  hsl_data,
    input  logic [KCH_BITS-1:0]  hsl_kchr,
    input  logic                 hsl_vld,
    output logic [FRM_BITS-1:0]  frm_data,
    output logic                 frm_vld,
    output logic                 frm_last,
    output logic                 frm_bad,
    output logic [SEQ_BITS-1:0]  frm_seq,
    output logic [CLR_BITS-1:0]  frm_colour,
    output logic                 ack_vld,
    output logic                 ack_type,
    output logic [CLR_BITS-1:0]  ack_colour,
    output logic [SEQ_BITS-1:0]  ack_seq,
    output logic                 ooc_vld,
    output logic [CLR_BITS-1:0]  ooc_colour,
    output logic                 cfc_vld,
    output logic [NUM_CHANS-1:0] cfc_rem,
    output logic                 reg_rfrm,
    output logic                 reg_crce,
    output logic                 reg_frme,
    output logic [IDLE_BITS-1:0] reg_idsi
);

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_ACK  = 8'hFC;
    localparam logic [7:0] K_NAK  = 8'h5C;
    localparam logic [7:0] K_OOC  = 8'h3C;
    localparam logic [7:0] K_CFC  = 8'hDC;
    localparam logic [7:0] K_HDR  = 8'hFB;

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    // CRC-16-CCITT (poly 0x1021), one full 32-bit word MSB-first
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    state_t               state, state_n;
    logic [2:0]           rem, rem_n;
    logic [15:0]          crc_q, crc_n;
    logic [FRM_BITS-1:0]  hold_q, hold_n;
    logic                 hold_vld, hold_vld_n;

    logic [FRM_BITS-1:0]  frm_data_n;
    logic                 frm_vld_n, frm_last_n, frm_bad_n;
    logic [SEQ_BITS-1:0]  frm_seq_n;
    logic [CLR_BITS-1:0]  frm_colour_n;
    logic                 ack_vld_n, ack_type_n;
    logic [CLR_BITS-1:0]  ack_colour_n;
    logic [SEQ_BITS-1:0]  ack_seq_n;
    logic                 ooc_vld_n;
    logic [CLR_BITS-1:0]  ooc_colour_n;
    logic                 cfc_vld_n;
    logic [NUM_CHANS-1:0] cfc_rem_n;
    logic                 reg_rfrm_n, reg_crce_n, reg_frme_n;
    logic [IDLE_BITS-1:0] reg_idsi_n;

    logic                 is_cc, is_k1, is_data, ctrl_ok, hunt;
    logic [15:0]          word_crc, hdr_crc;

    assign is_cc    = (hsl_kchr == 4'b1111);
    assign is_k1    = (hsl_kchr == 4'b1000);
    assign is_data  = (hsl_kchr == 4'b0000);
    assign word_crc = crc16_word(crc_q, hsl_data);
    assign hdr_crc  = crc16_word(16'hFFFF, hsl_data);
    assign ctrl_ok  = (crc16_word(16'hFFFF, {hsl_data[31:16], 16'h0000}) == hsl_data[15:0]);

    always_comb begin
        state_n      = state;
        rem_n        = rem;
        crc_n        = crc_q;
        hold_n       = hold_q;
        hold_vld_n   = hold_vld;
        frm_data_n   = frm_data;
        frm_vld_n    = 1'b0;
        frm_last_n   = 1'b0;
        frm_bad_n    = 1'b0;
        frm_seq_n    = frm_seq;
        frm_colour_n = frm_colour;
        ack_vld_n    = 1'b0;
        ack_type_n   = ack_type;
        ack_colour_n = ack_colour;
        ack_seq_n    = ack_seq;
        ooc_vld_n    = 1'b0;
        ooc_colour_n = ooc_colour;
        cfc_vld_n    = 1'b0;
        cfc_rem_n    = cfc_rem;
        reg_rfrm_n   = 1'b0;
        reg_crce_n   = 1'b0;
        reg_frme_n   = 1'b0;
        reg_idsi_n   = reg_idsi;
        hunt         = 1'b0;

        if (hsl_vld && !is_cc) begin
            case (state)
                PAYLOAD, CHECK: begin
                    if (is_data && state == PAYLOAD) begin
                        crc_n      = word_crc;
                        hold_n     = hsl_data;
                        hold_vld_n = 1'b1;
                        if (hold_vld) begin
                            frm_vld_n  = 1'b1;
                            frm_data_n = hold_q;
                        end
                        if (rem == 3'd0) state_n = CHECK;
                        else             rem_n   = rem - 3'd1;
                    end else if (is_data) begin
                        frm_vld_n  = 1'b1;
                        frm_last_n = 1'b1;
                        frm_data_n = hold_q;
                        frm_bad_n  = (crc_q != hsl_data[31:16]);
                        reg_rfrm_n = (crc_q == hsl_data[31:16]);
                        reg_crce_n = (crc_q != hsl_data[31:16]);
                        hold_vld_n = 1'b0;
                        state_n    = HUNT;
                    end else begin
                        // Abort: close the frame downstream only if it has started, then reparse the K-word
                        if (hold_vld) begin
                            frm_vld_n  = 1'b1;
                            frm_last_n = 1'b1;
                            frm_bad_n  = 1'b1;
                            frm_data_n = '0;
                        end
                        reg_frme_n = 1'b1;
                        hold_vld_n = 1'b0;
                        state_n    = HUNT;
                        hunt       = 1'b1;
                    end
                end
                default: hunt = 1'b1;
            endcase

            if (hunt) begin
                if (is_k1) begin
                    case (hsl_data[31:24])
                        K_IDLE: reg_idsi_n = hsl_data[IDLE_BITS-1:0];
                        K_ACK, K_NAK: begin
                            if (ctrl_ok) begin
                                ack_vld_n    = 1'b1;
                                ack_type_n   = (hsl_data[31:24] == K_ACK);
                                ack_colour_n = hsl_data[23 -: CLR_BITS];
                                ack_seq_n    = hsl_data[16 +: SEQ_BITS];
                            end else begin
                                reg_crce_n = 1'b1;
                            end
                        end
                        K_OOC: begin
                            if (ctrl_ok) begin
                                ooc_vld_n    = 1'b1;
                                ooc_colour_n = hsl_data[23 -: CLR_BITS];
                            end else begin
                                reg_crce_n = 1'b1;
                            end
                        end
                        K_CFC: begin
                            if (ctrl_ok) begin
                                cfc_vld_n = 1'b1;
                                cfc_rem_n = hsl_data[16 +: NUM_CHANS];
                            end else begin
                                reg_crce_n = 1'b1;
                            end
                        end
                        K_HDR: begin
                            rem_n        = hsl_data[23:21];
                            frm_seq_n    = hsl_data[14 +: SEQ_BITS];
                            frm_colour_n = hsl_data[13 -: CLR_BITS];
                            crc_n        = hdr_crc;
                            hold_vld_n   = 1'b0;
                            state_n      = PAYLOAD;
                        end
                        default: reg_frme_n = 1'b1;
                    endcase
                end else begin
                    reg_frme_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            rem        <= '0;
            crc_q      <= '0;
            hold_q     <= '0;
            hold_vld   <= 1'b0;
            frm_data   <= '0;
            frm_vld    <= 1'b0;
            frm_last   <= 1'b0;
            frm_bad    <= 1'b0;
            frm_seq    <= '0;
            frm_colour <= '0;
            ack_vld    <= 1'b0;
            ack_type   <= 1'b0;
            ack_colour <= '0;
            ack_seq    <= '0;
            ooc_vld    <= 1'b0;
            ooc_colour <= '0;
            cfc_vld    <= 1'b0;
            cfc_rem    <= '0;
            reg_rfrm   <= 1'b0;
            reg_crce   <= 1'b0;
            reg_frme   <= 1'b0;
            reg_idsi   <= '0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            crc_q      <= crc_n;
            hold_q     <= hold_n;
            hold_vld   <= hold_vld_n;
            frm_data   <= frm_data_n;
            frm_vld    <= frm_vld_n;
            frm_last   <= frm_last_n;
            frm_bad    <= frm_bad_n;
            frm_seq    <= frm_seq_n;
            frm_colour <= frm_colour_n;
            ack_vld    <= ack_vld_n;
            ack_type   <= ack_type_n;
            ack_colour <= ack_colour_n;
            ack_seq    <= ack_seq_n;
            ooc_vld    <= ooc_vld_n;
            ooc_colour <= ooc_colour_n;
            cfc_vld    <= cfc_vld_n;
            cfc_rem    <= cfc_rem_n;
            reg_rfrm   <= reg_rfrm_n;
            reg_crce   <= reg_crce_n;
            reg_frme   <= reg_frme_n;
            reg_idsi   <= reg_idsi_n;
        end
    end

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// Directed bench for spio_hss_multiplexer_frame_rx with hand-built frames and a CRC-16 model.
module tb_spio_hss_multiplexer_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hsl_data = '0;
    logic [3:0]  hsl_kchr = '0;
    logic        hsl_vld  = 1'b0;

    logic [31:0] frm_data;
    logic        frm_vld, frm_last, frm_bad;
    logic [6:0]  frm_seq;
    logic [0:0]  frm_colour;
    logic        ack_vld, ack_type;
    logic [0:0]  ack_colour;
    logic [6:0]  ack_seq;
    logic        ooc_vld;
    logic [0:0]  ooc_colour;
    logic        cfc_vld;
    logic [7:0]  cfc_rem;
    logic        reg_rfrm, reg_crce, reg_frme;
    logic [23:0] reg_idsi;

    int n_cmp = 0;
    int n_err = 0;

    spio_hss_multiplexer_frame_rx dut (
        .clk(clk), .rst(rst),
        .hsl_data(hsl_data), .hsl_kchr(hsl_kchr), .hsl_vld(hsl_vld),
        .frm_data(frm_data), .frm_vld(frm_vld), .frm_last(frm_last), .frm_bad(frm_bad),
        .frm_seq(frm_seq), .frm_colour(frm_colour),
        .ack_vld(ack_vld), .ack_type(ack_type), .ack_colour(ack_colour), .ack_seq(ack_seq),
        .ooc_vld(ooc_vld), .ooc_colour(ooc_colour),
        .cfc_vld(cfc_vld), .cfc_rem(cfc_rem),
        .reg_rfrm(reg_rfrm), .reg_crce(reg_crce), .reg_frme(reg_frme), .reg_idsi(reg_idsi)
    );

    always #5 clk = ~clk;

    // Reference CRC-16-CCITT, 0x1021, MSB-first over a whole 32-bit word
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 31; i >= 0; i--)
            r = (r << 1) ^ (((r[15] ^ d[i]) == 1'b1) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    function automatic logic [31:0] ctrl_word(input logic [7:0] k, input logic [7:0] fld);
        logic [31:0] w;
        w = {k, fld, 16'h0000};
        w[15:0] = crc_upd(16'hFFFF, w);
        return w;
    endfunction

    // Present one word for exactly one clock, then sample the registered response
    task automatic drive(input logic [3:0] k, input logic [31:0] d, input logic v);
        @(negedge clk);
        hsl_kchr = k;
        hsl_data = d;
        hsl_vld  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({frm_vld, frm_last, frm_bad, ack_vld, ooc_vld, cfc_vld, reg_rfrm, reg_crce, reg_frme} !== 9'b0) begin
            n_err++; $display("[TB] FAIL reset_pulses: got %b expected 0",
                {frm_vld, frm_last, frm_bad, ack_vld, ooc_vld, cfc_vld, reg_rfrm, reg_crce, reg_frme});
        end
        n_cmp++;
        if ({frm_data, frm_seq, reg_idsi, cfc_rem, ack_seq} !== '0) begin
            n_err++; $display("[TB] FAIL reset_fields: got %h expected 0", {frm_data, frm_seq, reg_idsi, cfc_rem, ack_seq});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        drive(4'b1000, 32'hBCA5A5A5, 1'b1);
        drive(4'b1111, 32'h1C1C1C1C, 1'b1);
        n_cmp++;
        if (reg_idsi !== 24'hA5A5A5) begin
            n_err++; $display("[TB] FAIL idle_sentinel: got %h expected a5a5a5", reg_idsi);
        end
        drive(4'b1111, 32'hBC000000, 1'b1);
        n_cmp++;
        if ({reg_idsi, frm_vld, ack_vld, ooc_vld, cfc_vld, reg_rfrm, reg_crce, reg_frme} !== {24'hA5A5A5, 7'b0}) begin
            n_err++; $display("[TB] FAIL idle_cc_quiet: got %h/%b expected a5a5a5/0", reg_idsi,
                {frm_vld, ack_vld, ooc_vld, cfc_vld, reg_rfrm, reg_crce, reg_frme});
        end
    endtask

    task automatic test_ack();
        logic [31:0] w;
        w = ctrl_word(8'hFC, {1'b1, 7'd42});
        drive(4'b1000, w, 1'b1);
        n_cmp++;
        if ({ack_vld, ack_type, ack_colour, ack_seq, reg_crce} !== {1'b1, 1'b1, 1'b1, 7'd42, 1'b0}) begin
            n_err++; $display("[TB] FAIL ack_fields: got vld=%b type=%b col=%b seq=%0d crce=%b expected 1/1/1/42/0",
                ack_vld, ack_type, ack_colour, ack_seq, reg_crce);
        end
        drive(4'b0000, 32'h0, 1'b0);
        n_cmp++;
        if (ack_vld !== 1'b0) begin
            n_err++; $display("[TB] FAIL ack_single_pulse: got %b expected 0", ack_vld);
        end
        drive(4'b1000, w ^ 32'h1, 1'b1);
        n_cmp++;
        if ({reg_crce, ack_vld} !== 2'b10) begin
            n_err++; $display("[TB] FAIL ack_bad_crc: got crce/ack=%b expected 10", {reg_crce, ack_vld});
        end
    endtask

    task automatic test_frame(input bit flip);
        logic [31:0] h, p0, p1, p2, p0_tx;
        logic [15:0] c;
        h  = {8'hFB, 3'd2, 7'd5, 1'b0, 13'h0};
        p0 = 32'h11112222;
        p1 = 32'h33334444;
        p2 = 32'h55556666;
        c  = crc_upd(crc_upd(crc_upd(crc_upd(16'hFFFF, h), p0), p1), p2);
        p0_tx = flip ? (p0 ^ 32'h1) : p0;

        drive(4'b1000, h, 1'b1);
        drive(4'b0000, p0_tx, 1'b1);
        n_cmp++;
        if (frm_vld !== 1'b0) begin
            n_err++; $display("[TB] FAIL frame%0d_first_word_held: got vld=%b expected 0", flip, frm_vld);
        end
        drive(4'b1111, 32'hBC95BC95, 1'b1);
        drive(4'b0000, p1, 1'b1);
        n_cmp++;
        if ({frm_vld, frm_last, frm_data} !== {2'b10, p0_tx}) begin
            n_err++; $display("[TB] FAIL frame%0d_beat0: got %b%b %h expected 10 %h", flip, frm_vld, frm_last, frm_data, p0_tx);
        end
        drive(4'b0000, 32'hFFFFFFFF, 1'b0);
        drive(4'b0000, p2, 1'b1);
        n_cmp++;
        if ({frm_vld, frm_last, frm_data} !== {2'b10, p1}) begin
            n_err++; $display("[TB] FAIL frame%0d_beat1: got %b%b %h expected 10 %h", flip, frm_vld, frm_last, frm_data, p1);
        end
        drive(4'b0000, {c, 16'h0000}, 1'b1);
        n_cmp++;
        if ({frm_vld, frm_last, frm_bad, frm_data} !== {2'b11, flip, p2}) begin
            n_err++; $display("[TB] FAIL frame%0d_last_beat: got %b%b%b %h expected 11%b %h",
                flip, frm_vld, frm_last, frm_bad, frm_data, flip, p2);
        end
        n_cmp++;
        if ({reg_rfrm, reg_crce, frm_seq} !== {~flip, flip, 7'd5}) begin
            n_err++; $display("[TB] FAIL frame%0d_status: got rfrm=%b crce=%b seq=%0d expected %b %b 5",
                flip, reg_rfrm, reg_crce, frm_seq, ~flip, flip);
        end
    endtask

    task automatic test_abort();
        logic [31:0] h1, h2, q0;
        logic [15:0] c;
        h1 = {8'hFB, 3'd3, 7'd9, 1'b1, 13'h0};
        h2 = {8'hFB, 3'd0, 7'd3, 1'b0, 13'h0};
        q0 = 32'hDEADBEEF;
        c  = crc_upd(crc_upd(16'hFFFF, h2), q0);
        drive(4'b1000, h1, 1'b1);
        drive(4'b0000, 32'hAAAA0001, 1'b1);
        drive(4'b0000, 32'hAAAA0002, 1'b1);
        drive(4'b1000, h2, 1'b1);
        n_cmp++;
        if ({frm_vld, frm_last, frm_bad, reg_frme, frm_data} !== {4'b1111, 32'h0}) begin
            n_err++; $display("[TB] FAIL abort_terminator: got %b%b%b frme=%b %h expected 1111 00000000",
                frm_vld, frm_last, frm_bad, reg_frme, frm_data);
        end
        drive(4'b0000, q0, 1'b1);
        n_cmp++;
        if (frm_vld !== 1'b0) begin
            n_err++; $display("[TB] FAIL abort_new_hold: got vld=%b expected 0", frm_vld);
        end
        drive(4'b0000, {c, 16'h0000}, 1'b1);
        n_cmp++;
        if ({frm_vld, frm_last, frm_bad, reg_rfrm, frm_seq, frm_data} !== {4'b1101, 7'd3, q0}) begin
            n_err++; $display("[TB] FAIL abort_new_frame: got %b%b%b rfrm=%b seq=%0d %h expected 1101 seq=3 %h",
                frm_vld, frm_last, frm_bad, reg_rfrm, frm_seq, frm_data, q0);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'b1000, ctrl_word(8'h3C, 8'h80), 1'b1);
        n_cmp++;
        if ({ooc_vld, ooc_colour, cfc_vld, ack_vld} !== 4'b1100) begin
            n_err++; $display("[TB] FAIL b2b_ooc: got %b expected 1100", {ooc_vld, ooc_colour, cfc_vld, ack_vld});
        end
        drive(4'b1000, ctrl_word(8'hDC, 8'h81), 1'b1);
        n_cmp++;
        if ({cfc_vld, cfc_rem, ooc_vld, ack_vld} !== {1'b1, 8'h81, 2'b00}) begin
            n_err++; $display("[TB] FAIL b2b_cfc: got vld=%b rem=%h ooc=%b ack=%b expected 1 81 0 0",
                cfc_vld, cfc_rem, ooc_vld, ack_vld);
        end
        drive(4'b1000, ctrl_word(8'h5C, {1'b0, 7'd100}), 1'b1);
        n_cmp++;
        if ({ack_vld, ack_type, ack_colour, ack_seq, cfc_vld} !== {3'b100, 7'd100, 1'b0}) begin
            n_err++; $display("[TB] FAIL b2b_nak: got vld=%b type=%b col=%b seq=%0d cfc=%b expected 1 0 0 100 0",
                ack_vld, ack_type, ack_colour, ack_seq, cfc_vld);
        end
        drive(4'b0000, 32'h12345678, 1'b1);
        n_cmp++;
        if ({reg_frme, frm_vld, ack_vld} !== 3'b100) begin
            n_err++; $display("[TB] FAIL hunt_data_frme: got %b expected 100", {reg_frme, frm_vld, ack_vld});
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_ack();
        test_frame(1'b0);
        test_frame(1'b1);
        test_abort();
        test_back_to_back();
        drive(4'b0000, 32'h0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
